// File: rtl/param_sync_dpram_pkg.sv
// param_dpram_pkg: read-latency limits and address-width helper shared by param_sync_dpram.
package param_dpram_pkg;
  localparam int MIN_RD_LAT = 1;
  localparam int MAX_RD_LAT = 4;
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/param_sync_dpram_if.sv
// param_sync_dpram_if: write port A / read port B bus of param_sync_dpram.
interface param_sync_dpram_if
  import param_dpram_pkg::*;
#(
  parameter int RAM_WIDTH = 64,
  parameter int COL_WIDTH = 8,
  parameter int RAM_DEPTH = 1024
) ();
  localparam int NB_COL = RAM_WIDTH / COL_WIDTH;
  localparam int ADDR_W = clogb2(RAM_DEPTH - 1);
  logic [NB_COL-1:0]    wea;
  logic [ADDR_W-1:0]    addra;
  logic [RAM_WIDTH-1:0] dina;
  logic                 enb;
  logic [ADDR_W-1:0]    addrb;
  logic [RAM_WIDTH-1:0] doutb;
  logic                 doutb_vld;
  modport master (output wea, addra, dina, enb, addrb, input doutb, doutb_vld);
  modport slave (input wea, addra, dina, enb, addrb, output doutb, doutb_vld);
endinterface

// File: rtl/param_sync_dpram_rd_pipe.sv
// dpram_rd_pipe: free-running data+valid delay line; data only advances alongside a valid so the tail holds.
module dpram_rd_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);
  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_data [STAGES];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_vld <= '0;
      for (int k = 0; k < STAGES; k++) r_data[k] <= '0;
    end else begin
      r_vld[0] <= i_vld;
      if (i_vld) r_data[0] <= i_data;
      for (int k = 1; k < STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) r_data[k] <= r_data[k-1];
      end
    end
  assign o_vld  = r_vld[STAGES-1];
  assign o_data = r_data[STAGES-1];
endmodule

// File: rtl/param_sync_dpram.sv
// param_sync_dpram: simple dual-port RAM with byte-lane writes and 1..4 cycle read latency plus valid strobe.
module param_sync_dpram
  import param_dpram_pkg::*;
#(
  parameter int    RAM_WIDTH    = 64,
  parameter int    COL_WIDTH    = 8,
  parameter int    RAM_DEPTH    = 1024,
  parameter int    READ_LATENCY = 2,
  parameter string INIT_FILE    = ""
) (
  input logic               clka,
  input logic               rst,
  param_sync_dpram_if.slave bus
);
  localparam int NB_COL = RAM_WIDTH / COL_WIDTH;
  localparam int ADDR_W = clogb2(RAM_DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(RAM_DEPTH);
  typedef struct packed {
    logic                 vld;
    logic [RAM_WIDTH-1:0] data;
  } rd_stage_t;
  typedef logic [RAM_WIDTH-1:0] mem_t [RAM_DEPTH];
  (* ram_style = "block" *) mem_t r_mem = '{default: '0};
  logic                 w_wr_ok;
  logic                 w_rd_ok;
  logic [RAM_WIDTH-1:0] w_rd;
  logic [RAM_WIDTH-1:0] w_s1_d;
  rd_stage_t            r_s1;
  assign w_wr_ok = {1'b0, bus.addra} < DEPTH_C;
  assign w_rd_ok = {1'b0, bus.addrb} < DEPTH_C;
  assign w_rd    = w_rd_ok ? r_mem[bus.addrb] : '0;
  always_ff @(posedge clka)
    for (int k = 0; k < NB_COL; k++)
      if (w_wr_ok && bus.wea[k]) r_mem[bus.addra][k*COL_WIDTH +: COL_WIDTH] <= bus.dina[k*COL_WIDTH +: COL_WIDTH];
`ifdef PARAM_SYNC_DPRAM_BYPASS_EN
  logic w_hit;
  assign w_hit = w_wr_ok && (bus.addra == bus.addrb);
  for (genvar i = 0; i < NB_COL; i++) begin : g_fwd
    assign w_s1_d[i*COL_WIDTH +: COL_WIDTH] = (w_hit && bus.wea[i]) ? bus.dina[i*COL_WIDTH +: COL_WIDTH]
                                                                    : w_rd[i*COL_WIDTH +: COL_WIDTH];
  end
`else
  assign w_s1_d = w_rd;
`endif
  always_ff @(posedge clka or posedge rst)
    if (rst) r_s1 <= '0;
    else begin
      r_s1.vld <= bus.enb;
      if (bus.enb) r_s1.data <= w_s1_d;
    end
  if (READ_LATENCY < MIN_RD_LAT || READ_LATENCY > MAX_RD_LAT) begin : g_bad_lat
    $error("param_sync_dpram: READ_LATENCY %0d outside 1..4", READ_LATENCY);
  end
  if (READ_LATENCY <= 1) begin : g_lat1
    assign bus.doutb     = r_s1.data;
    assign bus.doutb_vld = r_s1.vld;
  end else begin : g_pipe
    dpram_rd_pipe #(.WIDTH(RAM_WIDTH), .STAGES(READ_LATENCY - 1)) u_pipe (
      .clk   (clka),
      .rst   (rst),
      .i_vld (r_s1.vld),
      .i_data(r_s1.data),
      .o_vld (bus.doutb_vld),
      .o_data(bus.doutb)
    );
  end
endmodule
